// File: rtl/digitizer_pkg.sv
// digitizer_pkg
// Shared definitions for the ADC capture / packetizer slice.
//   SAMPLE_W, AXIS_W : sample width and packed stream width (two samples per beat)
//   pkt_state_t      : packetizer control states
//   REG_CTRL, REG_SIZE : register-block offsets of the arm bit and the packet size
package digitizer_pkg;

    localparam int SAMPLE_W = 16;
    localparam int AXIS_W   = 2 * SAMPLE_W;

    localparam logic [7:0] REG_CTRL = 8'h00;
    localparam logic [7:0] REG_SIZE = 8'h08;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } pkt_state_t;

endpackage

// File: rtl/pkt_sync_fifo.sv
// pkt_sync_fifo
// Single-clock first-word-fall-through FIFO carrying packed beats plus a last flag.
// A written word becomes visible on rd_data/empty one clock after the write, which
// gives the packetizer its registered output stage without extra storage.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (flushes contents)
//   wr_en, wr_data   : write request and word; ignored when full unless a read happens
//   rd_en            : pop the head word (ignored when empty)
//   rd_data          : head word, valid while empty is low
//   full             : every slot is occupied (including not-yet-visible words)
//   empty            : no visible word at the head
module pkt_sync_fifo #(
    parameter int WIDTH      = 33,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] visible_q, visible_d;
    logic             wr_seen_q;
    logic             do_push, do_pop;

    // A pop frees a slot in the same clock, so a full FIFO can still take a write then.
    assign do_pop  = rd_en && (visible_q != '0);
    assign do_push = wr_en && (!full || do_pop);
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (visible_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // count tracks real occupancy; visible lags writes by one clock
    always_comb begin
        count_d   = count_q;
        visible_d = visible_q;
        if (do_push) begin
            count_d = count_d + CNT_W'(1);
        end
        if (do_pop) begin
            count_d   = count_d - CNT_W'(1);
            visible_d = visible_d - CNT_W'(1);
        end
        if (wr_seen_q) begin
            visible_d = visible_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            visible_q <= '0;
            wr_seen_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            visible_q <= visible_d;
            wr_seen_q <= do_push;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage itself needs no reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/adc_stream_packetizer.sv
// adc_stream_packetizer
// Packs the captured ADC sample stream two samples per beat into fixed-length
// AXI4-Stream packets for the DMA S2MM channel.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   start, packet_size         : arm pulse and packet length in bytes (sampled on start)
//   sample_valid, sample_data  : incoming samples, already in the clk domain
//   m_axis_*                   : AXI4-Stream master towards the DMA
//   busy                       : capture or drain in progress
//   done                       : one-cycle pulse after the last beat is handshaken
//   overflow                   : sticky, a beat was dropped because the FIFO was full
//   size_err                   : sticky, start was rejected for a bad packet size
module adc_stream_packetizer #(
    parameter int SAMPLE_W   = digitizer_pkg::SAMPLE_W,
    parameter int AXIS_W     = digitizer_pkg::AXIS_W,
    parameter int FIFO_DEPTH = 16,
    parameter int SIZE_W     = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [SIZE_W-1:0]   packet_size,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic [AXIS_W-1:0]   m_axis_tdata,
    output logic [AXIS_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                size_err
);

    import digitizer_pkg::*;

    localparam int BEAT_W = SIZE_W - 2;

    pkt_state_t          state_q, state_d;
    logic [BEAT_W-1:0]   beats_total_q, beats_total_d;
    logic [BEAT_W-1:0]   beats_pushed_q, beats_pushed_d;
    logic                half_q, half_d;
    logic [SAMPLE_W-1:0] low_q, low_d;
    logic                overflow_q, overflow_d;
    logic                size_err_q, size_err_d;
    logic                done_q, done_d;

    logic                fifo_full, fifo_empty;
    logic [AXIS_W:0]     fifo_wdata, fifo_rdata;
    logic                pop, pair_done, push, push_last, size_bad;

    assign pop       = !fifo_empty && m_axis_tready;
    assign pair_done = (state_q == CAPTURE) && sample_valid && half_q;
    // Mirrors the FIFO's own acceptance rule so drops are counted exactly.
    assign push      = pair_done && (!fifo_full || pop);
    assign push_last = (beats_pushed_q == beats_total_q - BEAT_W'(1));
    assign size_bad  = (packet_size == '0) || (packet_size[1:0] != 2'b00);

    assign fifo_wdata = {push_last, sample_data, low_q};

    pkt_sync_fifo #(
        .WIDTH      (AXIS_W + 1),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (fifo_wdata),
        .rd_en   (m_axis_tready),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Control: arm, pack samples, count beats, wait for the tlast handshake.
    always_comb begin
        state_d        = state_q;
        beats_total_d  = beats_total_q;
        beats_pushed_d = beats_pushed_q;
        half_d         = half_q;
        low_d          = low_q;
        overflow_d     = overflow_q;
        size_err_d     = size_err_q;
        done_d         = 1'b0;
        case (state_q)
            IDLE: begin
                // done_q blocks a start arriving in the same clock as done
                if (start && !done_q) begin
                    if (size_bad) begin
                        size_err_d = 1'b1;
                    end else begin
                        beats_total_d  = packet_size[SIZE_W-1:2];
                        beats_pushed_d = '0;
                        half_d         = 1'b0;
                        overflow_d     = 1'b0;
                        size_err_d     = 1'b0;
                        state_d        = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    if (!half_q) begin
                        low_d  = sample_data;
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (push) begin
                            beats_pushed_d = beats_pushed_q + BEAT_W'(1);
                            if (push_last) begin
                                state_d = DRAIN;
                            end
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (pop && fifo_rdata[AXIS_W]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            beats_total_q  <= '0;
            beats_pushed_q <= '0;
            half_q         <= 1'b0;
            low_q          <= '0;
            overflow_q     <= 1'b0;
            size_err_q     <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            beats_total_q  <= beats_total_d;
            beats_pushed_q <= beats_pushed_d;
            half_q         <= half_d;
            low_q          <= low_d;
            overflow_q     <= overflow_d;
            size_err_q     <= size_err_d;
            done_q         <= done_d;
        end
    end

    // Payload is forced to zero while nothing is valid so reset shows a clean bus.
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : fifo_rdata[AXIS_W-1:0];
    assign m_axis_tlast  = !fifo_empty && fifo_rdata[AXIS_W];
    assign m_axis_tkeep  = '1;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign size_err      = size_err_q;

endmodule
